exe_vector_unit: RTL
====================

Name: exe_vector_unit

Overview:
- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the registered control word, ValA/ValB, DirWrite and the 25-element data vector D0..D24.
- Computes scalar ALU ops in one cycle and vector reductions over D0..D24 in multiple cycles, stalling decode via in_ready.
- Presents a registered result plus the forwarded control fields to the execute/memory pipeline register.

Parameters:
- DATA_W, 32, width of ValA, ValB, each D element and the result.
- N_ELEM, 25, number of vector elements (D0..D24).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  decode register holds a valid instruction.
- in_ready  out  1  unit can accept; low = stall decode.
- codigo_alu_in  in  4  operation code.
- mux_result_in  in  2  result-select control, forwarded.
- mux_dir_write_in, mux_dir_mem_in, mux_dato_in  in  1 each  mux controls, forwarded.
- write_mem_in, write_reg_in  in  1 each  write enables, forwarded.
- d_vec_in  in  N_ELEM*DATA_W  packed D0..D24; D0 = bits [31:0], Di = bits [32i+31:32i].
- val_a_in, val_b_in  in  DATA_W  operands.
- dir_write_in  in  5  destination register address.
- out_valid  out  1  one-cycle pulse: output fields hold a completed instruction.
- result_out  out  DATA_W  execute result.
- val_b_out  out  DATA_W  ValB forwarded (store data).
- dir_write_out  out  5  forwarded destination.
- mux_result_out  out  2  forwarded control.
- mux_dir_write_out, mux_dir_mem_out, mux_dato_out  out  1 each  forwarded controls.
- write_mem_out, write_reg_out  out  1 each  forwarded enables, gated by out_valid.

Behaviour:
- Clock and reset: one clock (clk); rst_n is a synchronous, active-low reset.
- Reset state:
  - Sampled low at an edge: state=IDLE, in_ready=1, every output register = 0.
  - Any in-flight reduction is discarded.
- Accept: occurs at an edge where in_valid=1 and in_ready=1. The accept snapshots all inputs, including d_vec_in, into internal registers; input changes after accept have no effect.
- Opcodes, single-cycle (result registered at the accepting edge, out_valid=1 in the following cycle):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 8 SHL: A << B[4:0]
  - 9 SHR logical: A >> B[4:0]
- Opcodes, reductions over D0..D24 (unsigned):
  - 5 SUM: modulo 2^DATA_W, wraps.
  - 6 MAX: accumulator starts at 0.
  - 7 MIN: accumulator starts at all-ones.
- Opcodes 10-15 are invalid: single-cycle, result_out=0, write_reg_out=0 and write_mem_out=0; out_valid still pulses.
- FSM states IDLE and RUN:
  - IDLE: in_ready=1. Accepting a reduction moves to RUN with idx=0 and the accumulator initialised.
  - RUN: in_ready=0. Each edge folds element D[idx] into the accumulator and increments idx.
  - The edge that folds idx=N_ELEM-1 registers the result, pulses out_valid and returns to IDLE.
  - The next instruction can be accepted at the edge after the one that returned to IDLE.
- Reduction latency: the result is registered at edge T0+N_ELEM (T0 = accepting edge), so out_valid is high in cycle T0+N_ELEM+1. in_ready is low for exactly N_ELEM cycles.
- Bubbles: in any cycle without a new completion, out_valid=0 and write_reg_out=write_mem_out=0. result_out, val_b_out, dir_write_out and the mux fields hold their last values.
- Forwarding: forwarded fields come from the snapshot taken at accept, not from the live inputs.
- Busy input: in_valid=1 while in RUN is not accepted; upstream holds its value.
- rst_n low during RUN: returns to IDLE at that edge, no out_valid, in_ready=1 in the next cycle.
- Back-to-back single-cycle ops: one accept per cycle, out_valid continuously high.

Test Plan:
- Reset: rst_n=0 for 2 edges with in_valid=1 -> all outputs 0, in_ready=1, no out_valid.
- Back-to-back scalars:
  - ADD A=0xFFFFFFFF, B=2, dir=5, write_reg=1 -> result 0x00000001, dir_write_out=5, write_reg_out=1.
  - Followed next cycle by SHL A=1, B=0x25 -> result 0x00000020.
  - out_valid high 2 consecutive cycles.
- SUM wrap: D[i]=0x10000000 for all i, accepted at T0 -> in_ready low 25 cycles, result 0x90000000 at edge T0+25, single out_valid pulse. Changing d_vec_in after T0 has no effect.
- MAX/MIN:
  - D[i]=i*3, D[17]=0xFFFFFFF0, MAX -> 0xFFFFFFF0.
  - Same vector, MIN -> 0.
  - in_valid held high during RUN; the second instruction is accepted only after completion.
- Reset mid-RUN: rst_n=0 at T0+10 of a SUM -> no out_valid, in_ready=1 next cycle, new ADD 3+4 -> 7.
- Invalid opcode 12 with write_reg=1, write_mem=1 -> result 0, write_reg_out=0, write_mem_out=0, out_valid=1. Idle cycles between instructions show write enables at 0.

Source files
------------

// File: rtl/exe_vector_unit.sv
// exe_vector_unit
//   Execute stage that sits right after the decode/execute pipeline register.
//   Scalar ALU ops complete in one cycle. Vector reductions (SUM/MAX/MIN over
//   the N_ELEM-entry data vector) fold one element per cycle, and decode is
//   held off through in_ready while a reduction runs.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   in_valid / in_ready     accept handshake with the decode register
//   codigo_alu_in           operation code
//   mux_*_in, write_*_in    control fields, forwarded to the output
//   d_vec_in                packed vector; element i = bits [DATA_W*i +: DATA_W]
//   val_a_in, val_b_in      scalar operands
//   dir_write_in            destination register address
//   out_valid               one-cycle pulse per completed instruction
//   result_out              execute result
//   val_b_out, dir_write_out, mux_*_out
//                           fields forwarded from the accepted instruction
//   write_mem_out, write_reg_out
//                           forwarded write enables, low whenever out_valid is low
module exe_vector_unit #(
  parameter int DATA_W = 32,
  parameter int N_ELEM = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               codigo_alu_in,
  input  logic [1:0]               mux_result_in,
  input  logic                     mux_dir_write_in,
  input  logic                     mux_dir_mem_in,
  input  logic                     mux_dato_in,
  input  logic                     write_mem_in,
  input  logic                     write_reg_in,
  input  logic [N_ELEM*DATA_W-1:0] d_vec_in,
  input  logic [DATA_W-1:0]        val_a_in,
  input  logic [DATA_W-1:0]        val_b_in,
  input  logic [4:0]               dir_write_in,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        result_out,
  output logic [DATA_W-1:0]        val_b_out,
  output logic [4:0]               dir_write_out,
  output logic [1:0]               mux_result_out,
  output logic                     mux_dir_write_out,
  output logic                     mux_dir_mem_out,
  output logic                     mux_dato_out,
  output logic                     write_mem_out,
  output logic                     write_reg_out
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SUM = 4'd5;
  localparam logic [3:0] OP_MAX = 4'd6;
  localparam logic [3:0] OP_MIN = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic is_reduce(input logic [3:0] op);
    return (op == OP_SUM) || (op == OP_MAX) || (op == OP_MIN);
  endfunction

  // Codes above SHR are undefined; they complete but must never write.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

  function automatic logic [DATA_W-1:0] scalar_op(input logic [3:0]        op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << b[4:0];
      OP_SHR:  r = a >> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] fold_op(input logic [3:0]        op,
                                                input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (op)
      OP_MAX:  r = (d > acc) ? d : acc;
      OP_MIN:  r = (d < acc) ? d : acc;
      default: r = acc + d;
    endcase
    return r;
  endfunction

  // MIN seeds with all-ones so the first element always wins.
  function automatic logic [DATA_W-1:0] acc_seed(input logic [3:0] op);
    return (op == OP_MIN) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic                       accept;

  logic [3:0]                 op_p0;
  logic [N_ELEM*DATA_W-1:0]   d_vec_p0;
  logic [DATA_W-1:0]          val_b_p0;
  logic [4:0]                 dir_write_p0;
  logic [1:0]                 mux_result_p0;
  logic                       mux_dir_write_p0;
  logic                       mux_dir_mem_p0;
  logic                       mux_dato_p0;
  logic                       write_mem_p0;
  logic                       write_reg_p0;

  logic [DATA_W-1:0]          acc_p1;
  logic [DATA_W-1:0]          elem_p1;
  logic [DATA_W-1:0]          acc_next_p1;

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign elem_p1     = d_vec_p0[idx*DATA_W +: DATA_W];
  assign acc_next_p1 = fold_op(op_p0, acc_p1, elem_p1);

  // Stage p0: snapshot of the accepted instruction, so later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0            <= codigo_alu_in;
      d_vec_p0         <= d_vec_in;
      val_b_p0         <= val_b_in;
      dir_write_p0     <= dir_write_in;
      mux_result_p0    <= mux_result_in;
      mux_dir_write_p0 <= mux_dir_write_in;
      mux_dir_mem_p0   <= mux_dir_mem_in;
      mux_dato_p0      <= mux_dato_in;
      write_mem_p0     <= write_mem_in;
      write_reg_p0     <= write_reg_in;
    end
  end

  // Stage p1: reduction accumulator, one element folded per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p1 <= acc_seed(codigo_alu_in);
    end else if (state == RUN) begin
      acc_p1 <= acc_next_p1;
    end
  end

  // Stage p2: control FSM and the registered output fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      idx               <= '0;
      out_valid         <= 1'b0;
      result_out        <= '0;
      val_b_out         <= '0;
      dir_write_out     <= '0;
      mux_result_out    <= '0;
      mux_dir_write_out <= 1'b0;
      mux_dir_mem_out   <= 1'b0;
      mux_dato_out      <= 1'b0;
      write_mem_out     <= 1'b0;
      write_reg_out     <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      write_mem_out <= 1'b0;
      write_reg_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_reduce(codigo_alu_in)) begin
              state <= RUN;
              idx   <= '0;
            end else begin
              out_valid         <= 1'b1;
              result_out        <= scalar_op(codigo_alu_in, val_a_in, val_b_in);
              val_b_out         <= val_b_in;
              dir_write_out     <= dir_write_in;
              mux_result_out    <= mux_result_in;
              mux_dir_write_out <= mux_dir_write_in;
              mux_dir_mem_out   <= mux_dir_mem_in;
              mux_dato_out      <= mux_dato_in;
              write_mem_out     <= write_mem_in && is_legal(codigo_alu_in);
              write_reg_out     <= write_reg_in && is_legal(codigo_alu_in);
            end
          end
        end
        RUN: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state             <= IDLE;
            out_valid         <= 1'b1;
            result_out        <= acc_next_p1;
            val_b_out         <= val_b_p0;
            dir_write_out     <= dir_write_p0;
            mux_result_out    <= mux_result_p0;
            mux_dir_write_out <= mux_dir_write_p0;
            mux_dir_mem_out   <= mux_dir_mem_p0;
            mux_dato_out      <= mux_dato_p0;
            write_mem_out     <= write_mem_p0;
            write_reg_out     <= write_reg_p0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
